// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the EX/MEM interface: stalls the pipeline while an access is outstanding.
// Optional DMEM_ERR_CHECK_EN flags misaligned, out-of-range and read+write accesses via err.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            req;
  logic            cap_write;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic            eff_write;
  logic [AW-1:0]   eff_idx;
  logic [31:0]     eff_wdata;
  logic            eff_err;
  logic            complete;
  logic [31:0]     mem [DEPTH];

  assign req = mem_read | mem_write;

`ifdef DMEM_ERR_CHECK_EN
  logic req_err;
  logic cap_err;
  logic err_q;

  assign req_err = (addr[1:0] != 2'b00) | (|addr[31:AW+2]) | (mem_read & mem_write);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_err <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && req)
        cap_err <= req_err;
      err_q <= complete & eff_err;
    end
  end

  assign eff_err = (state == IDLE) ? req_err : cap_err;
  assign err     = err_q;
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
  assign eff_err = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req)
        cnt <= CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
      else if (state == BUSY && cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (!rst)
      stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && req) begin
      cap_write <= mem_write;
      cap_idx   <= addr[AW+1:2];
      cap_wdata <= wdata;
    end
  end

  // With LATENCY=1 completion happens on the accepting edge, so live inputs stand in for the captured copy.
  always_comb begin
    eff_write = (state == IDLE) ? mem_write     : cap_write;
    eff_idx   = (state == IDLE) ? addr[AW+1:2]  : cap_idx;
    eff_wdata = (state == IDLE) ? wdata         : cap_wdata;
    complete  = (state != RESP) && (state_nxt == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst && complete && eff_write && !eff_err)
      mem[eff_idx] <= eff_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      ready <= 1'b0;
    end else begin
      ready <= complete;
      if (complete) begin
        if (eff_err)
          rdata <= '0;
        else if (!eff_write)
          rdata <= mem[eff_idx];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core: the target end of the EX/MEM stage's memRead/memWrite/address/write-data interface.
- Accepts one word access at a time and completes it after a fixed, parameterised latency.
- Drives a stall back to the hazard logic while the access is outstanding, then returns a one-cycle ready pulse with read data.
- Replaces the zero-latency data memory so that a multi-cycle memory can be modelled.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of two, at least 4.
LATENCY, 2, cycles from request acceptance to the ready pulse; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
mem_read  input  1  read request, held by the requester until ready.
mem_write  input  1  write request, held by the requester until ready.
addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
wdata  input  32  write data, sampled at acceptance.
rdata  output  32  read data, valid while ready=1; holds its value otherwise.
ready  output  1  one-cycle completion pulse.
stall  output  1  pipeline freeze request to the hazard unit.
err  output  1  access-error flag, pulses with ready (feature only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, asynchronous):
  - State becomes IDLE, the counter clears, rdata=0, ready=0, err=0 and stall is forced to 0.
  - Memory array contents are not reset.
- State IDLE:
  - If mem_read or mem_write is high, the block captures addr, wdata and the operation.
  - If both are high, the access is a write and the read is dropped.
  - stall is combinational in this cycle: stall = mem_read | mem_write.
  - Next state is RESP when LATENCY=1; otherwise BUSY with the counter set to LATENCY-2.
  - With no request, the block stays in IDLE with stall=0.
- State BUSY:
  - stall=1 and inputs are ignored; the captured values are used.
  - The counter decrements each cycle; when it reaches 0 the next state is RESP.
- Transition into RESP (that clock edge):
  - Write: mem[index] <= captured wdata.
  - Read: rdata <= mem[index].
  - The ready register is set.
- State RESP (exactly one cycle):
  - ready=1 and stall=0; the pipeline advances at the end of this cycle.
  - Inputs are ignored because they still carry the completed request.
  - Next state is IDLE. A request present in the following cycle is a new access.
- Timing:
  - A request first seen in cycle n gives ready in cycle n+LATENCY.
  - stall is high for cycles n through n+LATENCY-1, i.e. LATENCY cycles.
  - Back-to-back accesses therefore cost LATENCY+1 cycles each.
- rdata updates only on read completion; writes leave rdata unchanged.
- Address handling without the feature:
  - addr[1:0] is ignored.
  - Bits above log2(DEPTH)+1 are ignored, so addresses alias modulo DEPTH*4.
- Reset asserted mid-access (BUSY, or the accepting cycle): the access is abandoned and no write is performed. After reset releases, a still-held request is accepted afresh.

Optional Feature:
Macro DMEM_ERR_CHECK_EN.
- Defined:
  - At acceptance, the block flags an error if addr[1:0]!=0, or if any address bit above log2(DEPTH)+1 is set, or if both mem_read and mem_write are high.
  - A flagged access goes through the normal latency.
  - At completion no write occurs, rdata <= 0 and err=1 together with ready.
- Not defined:
  - err is constant 0.
  - Addresses wrap or alias as described above, and simultaneous read and write resolves to a write.

Test Plan:
- Write then read, LATENCY=2:
  - Write 0xDEADBEEF to addr 0x10 in cycle 0 -> stall=1 in cycles 0–1, ready pulse in cycle 2 with stall=0.
  - Then read addr 0x10 -> rdata=0xDEADBEEF while ready=1, exactly 2 cycles after the read is presented.
- Back-to-back, LATENCY=2:
  - Present a write to 0x04 (0x11111111), then in the cycle after ready a read of 0x04 -> two separate ready pulses 3 cycles apart, second rdata=0x11111111, no request lost or duplicated.
- Simultaneous read and write:
  - Assert mem_read=mem_write=1 at addr 0x20 with wdata 0x00001234 -> without the macro, a later read of 0x20 returns 0x00001234 and rdata is unchanged at completion.
  - With the macro: err=1 at ready and the location is unwritten.
- Reset mid-access:
  - With 0x10 holding 0xDEADBEEF, start a write of 0x55555555 to 0x10, then pull rst low during BUSY -> stall and ready fall to 0 immediately.
  - After release, a read of 0x10 returns 0xDEADBEEF.
- Aliasing and errors, DEPTH=256:
  - Write 0xCAFEF00D to addr 0x400 -> without the macro, a read of 0x000 returns 0xCAFEF00D.
  - With the macro: err=1 and no write; a write to addr 0x13 also gives err=1.
- LATENCY=1:
  - A read is presented in cycle 0 -> stall=1 only in cycle 0, ready=1 with valid rdata in cycle 1, and the block is back in IDLE in cycle 2.
